// File: rtl/serial_digit_alu_if.sv
// serial_digit_alu_if
//   Bundles the command, operand stream, result stream and status signals of
//   the serial digit ALU. The master side is the host / core datapath that
//   issues commands and streams operand digits; the slave side is the ALU.
//
//   command : start, op, decimal, cin, num_digits, abort   (master -> slave)
//   status  : busy, done, carry_out, zero                   (slave -> master)
//   input   : in_valid, in_a, in_b (master -> slave), in_ready (slave -> master)
//   output  : out_valid, out_digit, out_last (slave -> master), out_ready (master -> slave)
interface serial_digit_alu_if #(
  parameter int DIGIT_W = 4,
  parameter int CNT_W   = 5
);
  logic               start;
  logic [1:0]         op;
  logic               decimal;
  logic               cin;
  logic [CNT_W-1:0]   num_digits;
  logic               abort;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic [DIGIT_W-1:0] in_a;
  logic [DIGIT_W-1:0] in_b;
  logic               out_valid;
  logic               out_ready;
  logic [DIGIT_W-1:0] out_digit;
  logic               out_last;
  logic               done;
  logic               carry_out;
  logic               zero;

  modport master (
    output start, op, decimal, cin, num_digits, abort,
    output in_valid, in_a, in_b, out_ready,
    input  busy, in_ready, out_valid, out_digit, out_last,
    input  done, carry_out, zero
  );

  modport slave (
    input  start, op, decimal, cin, num_digits, abort,
    input  in_valid, in_a, in_b, out_ready,
    output busy, in_ready, out_valid, out_digit, out_last,
    output done, carry_out, zero
  );
endinterface

// File: rtl/serial_digit_alu.sv
// serial_digit_alu
//   Multi-digit sequential ALU. Operand digits stream in one pair per cycle,
//   the carry/borrow is chained across digits in a register, and one result
//   digit per accepted pair is presented on a single-entry output register.
//   Supports binary/BCD add and subtract and multi-digit rotate through carry.
//
//   Ports:
//     clock    : system clock, rising edge
//     reset_n  : asynchronous active-low reset
//     bus      : serial_digit_alu_if.slave (command, streams, status)
//
//   State table:
//     state  | meaning
//     IDLE   | waiting for start; status outputs hold the last result
//     RUN    | accepting operand digits and emitting result digits
//     FIN    | one-cycle completion; done is high, final carry/zero shown
module serial_digit_alu #(
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 16,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input logic               clock,
  input logic               reset_n,
  serial_digit_alu_if.slave bus
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ROL = 2'd2;

  // Two extra bits keep a + b + c (and the BCD +6 adjust) free of overflow.
  localparam int               SUM_W   = DIGIT_W + 2;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
  localparam logic             DEC_OK  = (DIGIT_W == 4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]         op_q;
  logic               dec_q;
  logic               carry_q;
  logic [CNT_W-1:0]   remaining;
  logic               zero_acc;
  logic               out_valid_q;
  logic               out_last_q;
  logic [DIGIT_W-1:0] out_digit_q;
  logic               carry_out_q;
  logic               zero_q;

  logic               busy_c;
  logic               done_c;
  logic               in_ready_c;
  logic               carry_out_c;
  logic               zero_c;

  logic [CNT_W-1:0]   len_clamped;
  logic               start_ok;
  logic               abort_run;
  logic               in_fire;
  logic               out_fire;
  logic               last_fire;
  logic               dec_en;

  logic [DIGIT_W-1:0] b_inv;
  logic [SUM_W-1:0]   b_term;
  logic [SUM_W-1:0]   sum;
  logic [SUM_W-1:0]   sum_adj;
  logic [DIGIT_W-1:0] dig_res;
  logic               c_res;

  assign len_clamped = (bus.num_digits > MAX_CNT) ? MAX_CNT : bus.num_digits;

  // abort has priority over a simultaneous start.
  assign start_ok  = (state == S_IDLE) && bus.start && !bus.abort;
  assign abort_run = bus.abort && (state != S_IDLE);
  assign in_fire   = bus.in_valid && in_ready_c;
  assign out_fire  = out_valid_q && bus.out_ready;
  assign last_fire = out_fire && out_last_q;

  // BCD mode only makes sense for 4-bit digits; wider or narrower is binary.
  assign dec_en = dec_q && DEC_OK;

  //--------------------------------------------------------------------------
  // Per-digit arithmetic on the incoming pair, using the chained carry.
  //--------------------------------------------------------------------------
  assign b_inv = ~bus.in_b;

  always_comb begin
    b_term  = '0;
    sum     = '0;
    sum_adj = '0;
    dig_res = '0;
    c_res   = carry_q;
    case (op_q)
      OP_ADD, OP_SUB: begin
        if (op_q == OP_ADD) begin
          b_term = SUM_W'(bus.in_b);
        end else if (dec_en) begin
          // Nine's complement for decimal subtract.
          b_term = SUM_W'(9) - SUM_W'(bus.in_b);
        end else begin
          b_term = SUM_W'(b_inv);
        end
        sum     = SUM_W'(bus.in_a) + b_term + SUM_W'(carry_q);
        sum_adj = sum + SUM_W'(6);
        if (dec_en) begin
          // Digits above 9 are not flagged; the adjust is applied blindly.
          if (sum > SUM_W'(9)) begin
            dig_res = sum_adj[DIGIT_W-1:0];
            c_res   = 1'b1;
          end else begin
            dig_res = sum[DIGIT_W-1:0];
            c_res   = 1'b0;
          end
        end else begin
          dig_res = sum[DIGIT_W-1:0];
          c_res   = sum[DIGIT_W];
        end
      end
      OP_ROL: begin
        dig_res = {bus.in_a[DIGIT_W-2:0], carry_q};
        c_res   = bus.in_a[DIGIT_W-1];
      end
      default: begin
        dig_res = {carry_q, bus.in_a[DIGIT_W-1:1]};
        c_res   = bus.in_a[0];
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = (len_clamped == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else if (last_fire) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    busy_c      = (state != S_IDLE);
    done_c      = (state == S_FIN) && !bus.abort;
    in_ready_c  = (state == S_RUN) && (remaining != '0) &&
                  (!out_valid_q || bus.out_ready);
    // During the done cycle the live result is shown; it is committed to the
    // held registers on the way back to IDLE so an abort can discard it.
    carry_out_c = done_c ? carry_q  : carry_out_q;
    zero_c      = done_c ? zero_acc : zero_q;
  end

  //--------------------------------------------------------------------------
  // Datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q        <= OP_ADD;
      dec_q       <= 1'b0;
      carry_q     <= 1'b0;
      remaining   <= '0;
      zero_acc    <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_digit_q <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      if (start_ok) begin
        op_q        <= bus.op;
        dec_q       <= bus.decimal;
        carry_q     <= bus.cin;
        remaining   <= len_clamped;
        zero_acc    <= 1'b1;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else if (abort_run) begin
        remaining   <= '0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else if (state == S_RUN) begin
        if (in_fire) begin
          // An accept always frees or refills the single output slot.
          out_digit_q <= dig_res;
          out_valid_q <= 1'b1;
          out_last_q  <= (remaining == CNT_W'(1));
          remaining   <= remaining - CNT_W'(1);
          carry_q     <= c_res;
          zero_acc    <= zero_acc & (dig_res == '0);
        end else if (out_fire) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      end

      if (done_c) begin
        carry_out_q <= carry_q;
        zero_q      <= zero_acc;
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_digit = out_digit_q;
  assign bus.out_last  = out_valid_q && out_last_q;
  assign bus.carry_out = carry_out_c;
  assign bus.zero      = zero_c;

endmodule
